// File: rtl/cpu_trace_capture_pkg.sv
// Shared trace record layout and record-type codes for the CPU trace capture block.
package simple_cpu_trace_pkg;

  localparam logic [2:0] TRACE_T_RF  = 3'd1;
  localparam logic [2:0] TRACE_T_MEM = 3'd2;
  localparam logic [2:0] TRACE_T_BR  = 3'd3;
  localparam logic [2:0] TRACE_T_JAL = 3'd4;

  localparam int unsigned REC_W = 107;

  localparam int unsigned REC_C_LSB    = 0;
  localparam int unsigned REC_B_LSB    = 8;
  localparam int unsigned REC_A_LSB    = 40;
  localparam int unsigned REC_PC_LSB   = 72;
  localparam int unsigned REC_TYPE_LSB = 104;

  // Field order matches the LSB offsets above (first field is most significant).
  typedef struct packed {
    logic [2:0]  rtype;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  c;
  } trace_rec_t;

endpackage

// File: rtl/cpu_trace_capture_if.sv
// Valid/ready record stream from the trace capture block to its consumer.
interface cpu_trace_capture_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [2:0]  rec_type;
  logic [31:0] rec_pc;
  logic [31:0] rec_a;
  logic [31:0] rec_b;
  logic [7:0]  rec_c;

  modport master (
    output rec_valid, rec_type, rec_pc, rec_a, rec_b, rec_c,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_type, rec_pc, rec_a, rec_b, rec_c,
    output rec_ready
  );
endinterface

// File: rtl/cpu_trace_capture_fifo.sv
// Trace record FIFO: register-array storage, head entry read straight from the array.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 107
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cpu_trace_capture.sv
// Per-retire trace record capture with FIFO buffering and drop accounting.
// Define TRACE_STALL_EN to back-pressure the CPU via trace_stall instead of dropping records.
module cpu_trace_capture
  import simple_cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trace_en,
  input  logic                retire,
  input  logic [31:0]         pc,
  input  logic [31:0]         next_pc,
  input  logic                is_branch,
  input  logic                is_jump,
  input  logic                rf_wen,
  input  logic [4:0]          rf_waddr,
  input  logic [31:0]         rf_wdata,
  input  logic                mem_write,
  input  logic                mem_read,
  input  logic [31:0]         mem_addr,
  input  logic [3:0]          mem_wstrb,
  input  logic [31:0]         mem_wdata,
  cpu_trace_capture_if.master rec,
  output logic                ovf,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic                trace_stall
);

  trace_rec_t             new_rec;
  logic [REC_W-1:0]       head;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   push, pop, drop, rf_keep;
  logic                   ovf_q;
  logic [DROP_W-1:0]      drop_cnt_q;

  assign rf_keep = rf_wen & (rf_waddr != 5'd0);

  always_comb begin
    new_rec       = '0;
    new_rec.pc    = pc;
    if (mem_write) begin
      new_rec.rtype = TRACE_T_MEM;
      new_rec.a     = mem_addr;
      new_rec.b     = mem_wdata;
      new_rec.c     = {4'b0, mem_wstrb};
    end else if (is_jump) begin
      new_rec.rtype = TRACE_T_JAL;
      new_rec.a     = next_pc;
      new_rec.b     = rf_wdata;
      new_rec.c     = {3'b0, rf_waddr};
    end else if (is_branch) begin
      new_rec.rtype = TRACE_T_BR;
      new_rec.a     = next_pc;
    end else begin
      new_rec.rtype = TRACE_T_RF;
      new_rec.a     = rf_keep ? {27'b0, rf_waddr} : 32'b0;
      new_rec.b     = rf_keep ? rf_wdata : 32'b0;
      new_rec.c     = {7'b0, mem_read};
    end
  end

  assign pop = rec.rec_valid & rec.rec_ready;

`ifdef TRACE_STALL_EN
  assign trace_stall = full & ~rec.rec_ready;
  assign push        = retire & trace_en & ~trace_stall;
`else
  assign trace_stall = 1'b0;
  assign push        = retire & trace_en;
`endif

  assign drop = push & full & ~pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (new_rec),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign rec.rec_valid = (count != '0);
  assign rec.rec_type  = head[REC_TYPE_LSB +: 3];
  assign rec.rec_pc    = head[REC_PC_LSB +: 32];
  assign rec.rec_a     = head[REC_A_LSB +: 32];
  assign rec.rec_b     = head[REC_B_LSB +: 32];
  assign rec.rec_c     = head[REC_C_LSB +: 8];
  assign ovf           = ovf_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench for cpu_trace_capture: directed scenarios plus randomized traffic vs a queue model.
module tb_cpu_trace_capture;

  localparam int DEPTH = 16;

  typedef struct {
    bit        retire;
    bit [31:0] pc, next_pc;
    bit        is_branch, is_jump, rf_wen;
    bit [4:0]  rf_waddr;
    bit [31:0] rf_wdata;
    bit        mem_write, mem_read;
    bit [31:0] mem_addr;
    bit [3:0]  mem_wstrb;
    bit [31:0] mem_wdata;
  } ret_t;

  typedef struct {
    bit [2:0]  typ;
    bit [31:0] pc, a, b;
    bit [7:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trace_en, retire, is_branch, is_jump, rf_wen, mem_write, mem_read;
  logic [31:0] pc, next_pc, rf_wdata, mem_addr, mem_wdata;
  logic [4:0]  rf_waddr;
  logic [3:0]  mem_wstrb;
  logic        ovf, trace_stall;
  logic [15:0] drop_cnt;

  cpu_trace_capture_if rec_if ();

  cpu_trace_capture #(
    .DEPTH  (DEPTH),
    .DROP_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trace_en    (trace_en),
    .retire      (retire),
    .pc          (pc),
    .next_pc     (next_pc),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .rec         (rec_if),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt),
    .trace_stall (trace_stall)
  );

  always #5 clk = ~clk;

  exp_t      model_q[$];
  bit        m_ovf;
  bit [15:0] m_drop;
  int        n_checks = 0;
  int        n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Record contents straight from the classification rules.
  function automatic exp_t expect_rec(input ret_t r);
    exp_t e;
    e.pc = r.pc;
    if (r.mem_write) begin
      e.typ = 3'd2; e.a = r.mem_addr; e.b = r.mem_wdata; e.c = {4'b0, r.mem_wstrb};
    end else if (r.is_jump) begin
      e.typ = 3'd4; e.a = r.next_pc; e.b = r.rf_wdata; e.c = {3'b0, r.rf_waddr};
    end else if (r.is_branch) begin
      e.typ = 3'd3; e.a = r.next_pc; e.b = 0; e.c = 0;
    end else begin
      e.typ = 3'd1;
      e.a = (r.rf_wen && r.rf_waddr != 0) ? {27'b0, r.rf_waddr} : 32'b0;
      e.b = (r.rf_wen && r.rf_waddr != 0) ? r.rf_wdata : 32'b0;
      e.c = {7'b0, r.mem_read};
    end
    return e;
  endfunction

  function automatic ret_t idle_ret();
    ret_t r = '{default: 0};
    return r;
  endfunction

  function automatic ret_t alu_ret(input bit [31:0] p);
    ret_t r = idle_ret();
    r.retire = 1; r.pc = p; r.next_pc = p + 4; r.rf_wen = 1;
    r.rf_waddr = 5'd9; r.rf_wdata = p ^ 32'h5a5a_0000;
    return r;
  endfunction

  function automatic ret_t rand_ret();
    ret_t r;
    r.retire    = ($urandom_range(0, 3) != 0);
    r.pc        = $urandom;
    r.next_pc   = $urandom;
    r.is_branch = ($urandom_range(0, 2) == 0);
    r.is_jump   = ($urandom_range(0, 3) == 0);
    r.rf_wen    = $urandom_range(0, 1);
    r.rf_waddr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    r.rf_wdata  = $urandom;
    r.mem_write = ($urandom_range(0, 3) == 0);
    r.mem_read  = $urandom_range(0, 1);
    r.mem_addr  = $urandom;
    r.mem_wstrb = 4'($urandom);
    r.mem_wdata = $urandom;
    return r;
  endfunction

  task automatic check_outputs(input string ctx);
    check_val({ctx, ".valid"}, rec_if.rec_valid, model_q.size() != 0);
    if (model_q.size() != 0) begin
      check_val({ctx, ".type"}, rec_if.rec_type, model_q[0].typ);
      check_val({ctx, ".pc"},   rec_if.rec_pc,   model_q[0].pc);
      check_val({ctx, ".a"},    rec_if.rec_a,    model_q[0].a);
      check_val({ctx, ".b"},    rec_if.rec_b,    model_q[0].b);
      check_val({ctx, ".c"},    rec_if.rec_c,    model_q[0].c);
    end
    check_val({ctx, ".ovf"},  ovf,      m_ovf);
    check_val({ctx, ".drop"}, drop_cnt, m_drop);
  endtask

  // Called at a falling edge: drive, check stall, clock, update model, check outputs.
  task automatic cycle(input ret_t r, input bit en, input bit ready);
    bit pop, att, exp_stall;
    retire = r.retire; pc = r.pc; next_pc = r.next_pc; is_branch = r.is_branch;
    is_jump = r.is_jump; rf_wen = r.rf_wen; rf_waddr = r.rf_waddr; rf_wdata = r.rf_wdata;
    mem_write = r.mem_write; mem_read = r.mem_read; mem_addr = r.mem_addr;
    mem_wstrb = r.mem_wstrb; mem_wdata = r.mem_wdata; trace_en = en;
    rec_if.rec_ready = ready;
    #1;
`ifdef TRACE_STALL_EN
    exp_stall = (model_q.size() == DEPTH) && !ready;
`else
    exp_stall = 0;
`endif
    check_val("stall", trace_stall, exp_stall);
    @(posedge clk);
    pop = (model_q.size() != 0) && ready;
    att = r.retire && en && !exp_stall;
    if (pop) void'(model_q.pop_front());
    if (att) begin
      if (model_q.size() < DEPTH) model_q.push_back(expect_rec(r));
      else begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && model_q.size() != 0; i++) cycle(idle_ret(), 1, 1);
  endtask

  initial begin
    ret_t r;
    trace_en = 0; retire = 0; pc = 0; next_pc = 0; is_branch = 0; is_jump = 0; rf_wen = 0;
    rf_waddr = 0; rf_wdata = 0; mem_write = 0; mem_read = 0; mem_addr = 0; mem_wstrb = 0;
    mem_wdata = 0; rec_if.rec_ready = 0;
    m_ovf = 0; m_drop = 0;

    #2 rst = 1;
    #1;
    check_val("rst.valid", rec_if.rec_valid, 0);
    check_val("rst.pc", rec_if.rec_pc, 0);
    check_val("rst.type", rec_if.rec_type, 0);
    check_val("rst.ovf", ovf, 0);
    check_val("rst.drop", drop_cnt, 0);
    check_val("rst.stall", trace_stall, 0);
    @(negedge clk);
    rst = 0;

    // addi x5
    r = idle_ret(); r.retire = 1; r.pc = 0; r.next_pc = 4; r.rf_wen = 1;
    r.rf_waddr = 5; r.rf_wdata = 32'h12;
    cycle(r, 1, 1);
    check_val("t1.type", rec_if.rec_type, 1);
    check_val("t1.a", rec_if.rec_a, 5);
    check_val("t1.b", rec_if.rec_b, 32'h12);
    check_val("t1.c", rec_if.rec_c, 0);

    // store with rf_wen also set
    r = idle_ret(); r.retire = 1; r.pc = 32'h8; r.next_pc = 32'hC; r.mem_write = 1;
    r.mem_addr = 32'h100; r.mem_wstrb = 4'h3; r.mem_wdata = 32'hBEEF;
    r.rf_wen = 1; r.rf_waddr = 7; r.rf_wdata = 32'h55;
    cycle(r, 1, 1);
    check_val("t2.type", rec_if.rec_type, 2);
    check_val("t2.a", rec_if.rec_a, 32'h100);
    check_val("t2.b", rec_if.rec_b, 32'hBEEF);
    check_val("t2.c", rec_if.rec_c, 8'h03);

    // jal then beq
    r = idle_ret(); r.retire = 1; r.pc = 32'h10; r.next_pc = 32'h40; r.is_jump = 1;
    r.rf_wen = 1; r.rf_waddr = 1; r.rf_wdata = 32'h14;
    cycle(r, 1, 1);
    check_val("t4.type", rec_if.rec_type, 4);
    check_val("t4.a", rec_if.rec_a, 32'h40);
    check_val("t4.b", rec_if.rec_b, 32'h14);
    check_val("t4.c", rec_if.rec_c, 1);
    r = idle_ret(); r.retire = 1; r.pc = 32'h14; r.next_pc = 32'h18; r.is_branch = 1;
    r.rf_wen = 1; r.rf_waddr = 3; r.rf_wdata = 32'h9;
    cycle(r, 1, 1);
    check_val("t3.type", rec_if.rec_type, 3);
    check_val("t3.a", rec_if.rec_a, 32'h18);
    check_val("t3.b", rec_if.rec_b, 0);
    check_val("t3.c", rec_if.rec_c, 0);

    // load writing x0: register fields suppressed, mem_read visible
    r = idle_ret(); r.retire = 1; r.pc = 32'h18; r.rf_wen = 1; r.rf_waddr = 0;
    r.rf_wdata = 32'hDEAD; r.mem_read = 1;
    cycle(r, 1, 1);
    check_val("x0.a", rec_if.rec_a, 0);
    check_val("x0.b", rec_if.rec_b, 0);
    check_val("x0.c", rec_if.rec_c, 1);
    drain();

    // 18 retires into a stalled consumer
    for (int i = 0; i < 18; i++) cycle(alu_ret(32'h1000 + 4 * i), 1, 0);
`ifdef TRACE_STALL_EN
    check_val("ovf18.ovf", ovf, 0);
    check_val("ovf18.drop", drop_cnt, 0);
    check_val("ovf18.stall", trace_stall, 1);
`else
    check_val("ovf18.ovf", ovf, 1);
    check_val("ovf18.drop", drop_cnt, 2);
    check_val("ovf18.stall", trace_stall, 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      check_val("ovf18.order", rec_if.rec_pc, 32'h1000 + 4 * i);
      cycle(idle_ret(), 1, 1);
    end
    check_val("ovf18.empty", rec_if.rec_valid, 0);

    // full FIFO: simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cycle(alu_ret(32'h2000 + 4 * i), 1, 0);
    cycle(alu_ret(32'h3000), 1, 1);
    check_val("fullpp.head", rec_if.rec_pc, 32'h2004);
    cycle(alu_ret(32'h4000), 1, 0);
`ifndef TRACE_STALL_EN
    check_val("fullpp.drop", drop_cnt, 3);
`endif
    for (int i = 1; i < DEPTH; i++) begin
      check_val("fullpp.order", rec_if.rec_pc, 32'h2000 + 4 * i);
      cycle(idle_ret(), 1, 1);
    end
    check_val("fullpp.tail", rec_if.rec_pc, 32'h3000);
    drain();

    // reset with records queued, mid-handshake
    for (int i = 0; i < 5; i++) cycle(alu_ret(32'h5000 + 4 * i), 1, 0);
    rec_if.rec_ready = 1;
    #2 rst = 1;
    #1;
    check_val("rstmid.valid", rec_if.rec_valid, 0);
    check_val("rstmid.ovf", ovf, 0);
    check_val("rstmid.drop", drop_cnt, 0);
    check_val("rstmid.pc", rec_if.rec_pc, 0);
    model_q.delete();
    m_ovf = 0; m_drop = 0;
    @(negedge clk);
    rst = 0;
    cycle(idle_ret(), 1, 1);
    check_val("rstmid.empty", rec_if.rec_valid, 0);

    // randomized traffic with varying consumer back-pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        bit rdy, en;
        case (ph)
          0: rdy = ($urandom_range(0, 9) != 0);
          1: rdy = $urandom_range(0, 1);
          2: rdy = ($urandom_range(0, 9) == 0);
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        en = ($urandom_range(0, 7) != 0);
        cycle(rand_ret(), en, rdy);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
